reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of release-synchroniser flops (legal 2..4).
REQ-002 Parameter INIT_ASSERT_CYCLES, default 16, assert length of the power-on sequence in clock cycles.
REQ-003 Parameter SETTLE_CYCLES, default 2, cycles between sync_reset deassertion and reset_done.
REQ-004 Port clock  in  1  free-running clock produced by the clock generator; all logic on its rising edge.
REQ-005 Port reset  in  1  asynchronous, active-high reset; one clock domain only.
REQ-006 Port reset_req  in  1  request for a new reset sequence; sampled on each rising edge.
REQ-007 Port assert_cycles  in  16  programmed assert length for subsequent sequences.
REQ-008 Port assert_cycles_load  in  1  captures assert_cycles into the program register.
REQ-009 Port sync_reset  out  1  registered active-high reset driven to the DUT.
REQ-010 Port busy  out  1  high while a sequence is in progress (ASSERT or SETTLE).
REQ-011 Port reset_done  out  1  one-cycle pulse marking the end of each sequence.
REQ-012 Port seq_count  out  8  count of completed sequences, saturating.

Function
REQ-013 The FSM SHALL have four states: SYNC -> ASSERT -> SETTLE -> IDLE.
REQ-014 SYNC: hold while the synchronised release is high; on release, go to ASSERT with the counter loaded to the program value.
REQ-015 ASSERT: decrement the counter each edge; at count 1, go to SETTLE with sync_reset=0 on that edge.
REQ-016 Assert length: sync_reset SHALL stay high for exactly N cycles after SYNC exit, where N is the program value.
REQ-017 SETTLE: count SETTLE_CYCLES edges, then go to IDLE, asserting reset_done for one cycle and incrementing seq_count on the same edge.
REQ-018 IDLE: a reset_req sampled high SHALL set sync_reset=1 and busy=1 on that edge and enter ASSERT with the counter loaded to N.
REQ-019 IDLE request timing: sync_reset high on edges k..k+N-1, low from edge k+N; reset_done high in the cycle after edge k+N+SETTLE_CYCLES.
REQ-020 A reset_req in ASSERT SHALL reload the counter to N, extending the assertion.
REQ-021 A reset_req in SETTLE SHALL return the FSM to ASSERT with sync_reset=1 and counter=N; reset_done does not pulse and seq_count does not change.
REQ-022 assert_cycles_load SHALL update the program register on any edge in any state, affecting only later counter loads.
REQ-023 If load and reset_req coincide in IDLE, the new value SHALL be used for that sequence.
REQ-024 A program value of 0 SHALL be treated as 1; the counter is 16 bits.
REQ-025 seq_count SHALL saturate at 255 and never wrap.
REQ-026 busy SHALL equal (state==SYNC || state==ASSERT || state==SETTLE).

Reset
REQ-027 On reset assertion, asynchronously and without a clock: sync_reset=1, busy=1, reset_done=0, seq_count=0, state=SYNC, program register=INIT_ASSERT_CYCLES, synchroniser flops all 1.
REQ-028 Reset release SHALL propagate through SYNC_STAGES flops; first counting edge = SYNC_STAGES-th edge after release.
REQ-029 Reset asserted mid-sequence SHALL abort it immediately with no reset_done pulse; the power-on sequence then restarts.
REQ-030 The power-on sequence SHALL count as a sequence, so its reset_done sets seq_count to 1.

Structure
REQ-031 Package reset_sequencer_pkg SHALL hold the state enum, the counter width constant (16) and the seq_count width (8).
REQ-032 Sub-module reset_release_sync SHALL implement the SYNC_STAGES flop chain with async set and synchronous release.

Verification
REQ-033 Power-on: defaults, release reset -> sync_reset low at edge 2+16, reset_done at edge 2+16+2, seq_count=1.
REQ-034 Program 5, reset_req at edge k in IDLE -> sync_reset high edges k..k+4, reset_done at k+7, seq_count=2.
REQ-035 Program 0 then reset_req -> 1-cycle assertion; reset_req repeated in ASSERT -> assertion extended by N from the repeat edge.
REQ-036 reset_req during SETTLE -> back to ASSERT, no reset_done, seq_count unchanged until the next completion.
REQ-037 Assert reset mid-ASSERT for a sub-cycle glitch -> sync_reset high immediately, seq_count=0, full power-on sequence replays.
REQ-038 Run 300 sequences -> seq_count holds at 255.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg: shared state encoding, widths and helpers for the reset sequencer
package reset_sequencer_pkg;
  typedef enum logic [1:0] {S_SYNC, S_ASSERT, S_SETTLE, S_IDLE} state_t;
  localparam int CNT_W = 16;
  localparam int SEQ_W = 8;
  function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction
endpackage

// File: rtl/reset_release_sync.sv
// reset_release_sync: async-set, sync-release flop chain for the external reset
//   clock : sequencer clock
//   reset : asynchronous active-high reset
//   held  : high while the synchronised reset is still asserted
module reset_release_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  output logic held
);
  logic [STAGES-1:0] chain;
  always_ff @(posedge clock or posedge reset)
    if (reset) chain <= '1;
    else chain <= {chain[STAGES-2:0], 1'b0};
  assign held = chain[STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: power-on and on-request reset pulse generator with settle and completion count
//   clock, reset        : clock and asynchronous active-high reset
//   reset_req           : start (or extend) a reset sequence
//   assert_cycles(_load): program register for the assert length of later sequences
//   sync_reset          : registered reset to the downstream logic
//   busy                : sequence in progress
//   reset_done          : one-cycle pulse at sequence completion
//   seq_count           : saturating count of completed sequences
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int INIT_ASSERT_CYCLES = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             reset_req,
  input  logic [CNT_W-1:0] assert_cycles,
  input  logic             assert_cycles_load,
  output logic             sync_reset,
  output logic             busy,
  output logic             reset_done,
  output logic [SEQ_W-1:0] seq_count
);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES < 1 ? 1 : SETTLE_CYCLES);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, prog, prog_eff, cur;
  logic held, done_n;
  reset_release_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clock(clock),
    .reset(reset),
    .held (held)
  );
  // a load coinciding with a request applies to that request
  assign prog_eff = at_least_one(assert_cycles_load ? assert_cycles : prog);
  // the edge that releases SYNC already counts as the first assert cycle of length N
  assign cur = (state == S_SYNC) ? prog_eff : cnt;
  assign busy = (state != S_IDLE);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    done_n = 1'b0;
    case (state)
      S_SYNC, S_ASSERT:
        if (state == S_ASSERT || !held) begin
          if (reset_req) begin
            state_n = S_ASSERT;
            cnt_n = prog_eff;
          end else if (cur <= 16'd1) begin
            state_n = S_SETTLE;
            cnt_n = SETTLE_LD;
          end else begin
            state_n = S_ASSERT;
            cnt_n = cur - 16'd1;
          end
        end
      S_SETTLE:
        if (reset_req) begin
          state_n = S_ASSERT;
          cnt_n = prog_eff;
        end else if (cnt <= 16'd1) begin
          state_n = S_IDLE;
          done_n = 1'b1;
        end else cnt_n = cnt - 16'd1;
      S_IDLE:
        if (reset_req) begin
          state_n = S_ASSERT;
          cnt_n = prog_eff;
        end
      default: state_n = S_SYNC;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= S_SYNC;
      cnt <= '0;
      prog <= CNT_W'(INIT_ASSERT_CYCLES);
      sync_reset <= 1'b1;
      reset_done <= 1'b0;
      seq_count <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sync_reset <= (state_n == S_SYNC) || (state_n == S_ASSERT);
      reset_done <= done_n;
      if (assert_cycles_load) prog <= assert_cycles;
      if (done_n && seq_count != '1) seq_count <= seq_count + 1'b1;
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed and random checks of reset_sequencer against a deadline-based model
module tb_reset_sequencer;
  localparam int S = 2, INIT = 16, SET = 2;
  logic clock = 0, reset = 0, reset_req = 0, assert_cycles_load = 0;
  logic [15:0] assert_cycles = 0;
  logic sync_reset, busy, reset_done;
  logic [7:0] seq_count;
  int errors = 0, checks = 0;
  int e, sr_low_at, done_at, m_count, prog;

  always #5 clock = ~clock;

  reset_sequencer #(.SYNC_STAGES(S), .INIT_ASSERT_CYCLES(INIT), .SETTLE_CYCLES(SET)) dut (
    .clock(clock),
    .reset(reset),
    .reset_req(reset_req),
    .assert_cycles(assert_cycles),
    .assert_cycles_load(assert_cycles_load),
    .sync_reset(sync_reset),
    .busy(busy),
    .reset_done(reset_done),
    .seq_count(seq_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, e, obs, exp);
    end
  endtask

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // model: a sequence is two deadlines -- the edge sync_reset drops and the edge reset_done fires
  task automatic model_reset();
    e = 0;
    prog = INIT;
    m_count = 0;
    sr_low_at = S + INIT;
    done_at = S + INIT + SET;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_sr"}, sync_reset, 1);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_done"}, reset_done, 0);
    chk({tag, "_cnt"}, seq_count, 0);
  endtask

  // called between edges: drive, take one rising edge, check, move to the falling edge
  task automatic step(input bit req, input bit ld, input int val);
    int n;
    reset_req = req;
    assert_cycles_load = ld;
    assert_cycles = 16'(val);
    @(posedge clock);
    e++;
    n = ld ? eff(val) : eff(prog);
    if (ld) prog = val;
    if (req && e > S) begin
      sr_low_at = e + n;
      done_at = e + n + SET;
    end
    if (e == done_at && m_count < 255) m_count++;
    #1;
    chk("sync_reset", sync_reset, (e < sr_low_at));
    chk("busy", busy, (e < done_at));
    chk("reset_done", reset_done, (e == done_at));
    chk("seq_count", seq_count, 16'(m_count));
    @(negedge clock);
    reset_req = 0;
    assert_cycles_load = 0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0);
  endtask

  initial begin
    e = 0;
    #1 reset = 1;
    #1 check_reset_state("async_reset");
    repeat (3) @(posedge clock);
    #1 check_reset_state("held_reset");
    @(negedge clock);
    reset = 0;
    model_reset();
    idle(17);
    chk("po_sr_e17", sync_reset, 1);
    idle(1);
    chk("po_sr_e18", sync_reset, 0);
    idle(2);
    chk("po_done_e20", reset_done, 1);
    chk("po_count", seq_count, 1);
    idle(3);
    step(0, 1, 5);
    step(1, 0, 0);
    idle(4);
    chk("p5_sr_k4", sync_reset, 1);
    idle(1);
    chk("p5_sr_k5", sync_reset, 0);
    idle(2);
    chk("p5_done_k7", reset_done, 1);
    chk("p5_count", seq_count, 2);
    step(0, 1, 0);
    step(1, 0, 0);
    chk("p0_sr", sync_reset, 1);
    idle(1);
    chk("p0_sr_low", sync_reset, 0);
    idle(4);
    step(0, 1, 3);
    step(1, 0, 0);
    idle(1);
    step(1, 0, 0);
    idle(8);
    step(1, 1, 4);
    idle(8);
    step(1, 0, 0);
    idle(4);
    step(1, 0, 0);
    chk("settle_req_sr", sync_reset, 1);
    idle(8);
    step(1, 0, 0);
    idle(2);
    #1 reset = 1;
    #1 check_reset_state("glitch");
    reset = 0;
    model_reset();
    idle(22);
    chk("replay_count", seq_count, 1);
    for (int i = 0; i < 1500; i++) begin
      bit r, l;
      r = ($urandom_range(0, 7) == 0);
      l = !r && ($urandom_range(0, 15) == 0);
      step(r, l, $urandom_range(0, 6));
    end
    idle(40);
    step(0, 1, 1);
    for (int i = 0; i < 300; i++) begin
      step(1, 0, 0);
      idle(3);
    end
    chk("saturate", seq_count, 255);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
